ex_regincr_reg_incr_pipe: RTL and testbench

//  Parametrised, pipelined registered incrementer with val/rdy handshakes on both sides.

---
 rtl/ex_regincr_pkg.sv | 24 ++
 rtl/ex_regincr_incr_stage.sv | 55 +++++
 rtl/ex_regincr_reg_incr_pipe.sv | 103 ++++++++++
 tb/tb_ex_regincr_reg_incr_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_regincr_pkg.sv
// Shared types and elaboration helpers for the regincr pipelined incrementer.
package ex_regincr_pkg;

   typedef enum logic {
      INCR_WRAP = 1'b0,
      INCR_SAT  = 1'b1
   } incr_mode_e;

   // The occupancy counter must be able to hold 0..nstages inclusive.
   function automatic int occ_width(input int nstages);
      return $clog2(nstages + 1);
   endfunction

   function automatic incr_mode_e mode_of(input int sat);
      incr_mode_e m;
      if (sat != 0) begin
         m = INCR_SAT;
      end else begin
         m = INCR_WRAP;
      end
      return m;
   endfunction

endpackage

// File: rtl/ex_regincr_incr_stage.sv
// One pipeline stage: val/data/ovf registers fed by an add-and-wrap/saturate
// of the upstream value; holds its contents whenever it is not allowed to advance.
module ex_regincr_incr_stage
   import ex_regincr_pkg::*;
#(
   parameter int         p_nbits = 8,
   parameter int         p_incr  = 1,
   parameter incr_mode_e p_mode  = INCR_WRAP
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               adv,
   input  logic               prev_val,
   input  logic [p_nbits-1:0] prev_data,
   input  logic               prev_ovf,
   output logic               val,
   output logic [p_nbits-1:0] data,
   output logic               ovf
);

   localparam logic [p_nbits:0] c_incr = (p_nbits + 1)'(p_incr);

   logic [p_nbits:0]   sum;
   logic               carry;
   logic [p_nbits-1:0] next_data;

   // Widened add so the carry out of the top bit is visible.
   always_comb begin
      sum   = {1'b0, prev_data} + c_incr;
      carry = sum[p_nbits];
      if ((p_mode == INCR_SAT) && carry) begin
         next_data = '1;
      end else begin
         next_data = sum[p_nbits-1:0];
      end
   end

   // Stage registers; data/ovf are don't-care whenever val is low.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         val  <= 1'b0;
         data <= '0;
         ovf  <= 1'b0;
      end else if (adv) begin
         val  <= prev_val;
         data <= next_data;
         ovf  <= prev_ovf | carry;
      end else begin
         val  <= val;
         data <= data;
         ovf  <= ovf;
      end
   end

endmodule

// File: rtl/ex_regincr_reg_incr_pipe.sv
// Pipelined registered incrementer with val/rdy on both sides: p_nstages stages
// each add p_incr, bubbles collapse so empty stages never stall upstream.
module ex_regincr_reg_incr_pipe
   import ex_regincr_pkg::*;
#(
   parameter int p_nbits   = 8,
   parameter int p_nstages = 2,
   parameter int p_incr    = 1,
   parameter int p_sat     = 0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_val,
   output logic                           in_rdy,
   input  logic [p_nbits-1:0]             in_msg,
   output logic                           out_val,
   input  logic                           out_rdy,
   output logic [p_nbits-1:0]             out_msg,
   output logic                           out_ovf,
   output logic [$clog2(p_nstages+1)-1:0] occ
);

   localparam int         c_occ_w = occ_width(p_nstages);
   localparam incr_mode_e c_mode  = mode_of(p_sat);

   logic [p_nstages-1:0]              val;
   logic [p_nstages-1:0]              ovf;
   logic [p_nstages-1:0]              adv;
   logic [p_nstages-1:0]              prev_val;
   logic [p_nstages-1:0]              prev_ovf;
   logic [p_nstages-1:0][p_nbits-1:0] data;
   logic [p_nstages-1:0][p_nbits-1:0] prev_data;
   logic                              in_fire;
   logic                              out_fire;

   // Stage i may advance if downstream drains or any stage from i onward is empty.
   always_comb begin
      logic hole;
      adv  = '0;
      hole = 1'b0;
      for (int i = 0; i < p_nstages; i++) begin
         hole = 1'b0;
         for (int j = i; j < p_nstages; j++) begin
            hole = hole | ~val[j];
         end
         adv[i] = out_rdy | hole;
      end
   end

   // Upstream feed for each stage; stage 0 starts with no overflow history.
   always_comb begin
      prev_val     = '0;
      prev_ovf     = '0;
      prev_data    = '0;
      prev_val[0]  = in_val;
      prev_data[0] = in_msg;
      prev_ovf[0]  = 1'b0;
      for (int i = 1; i < p_nstages; i++) begin
         prev_val[i]  = val[i-1];
         prev_data[i] = data[i-1];
         prev_ovf[i]  = ovf[i-1];
      end
   end

   for (genvar g = 0; g < p_nstages; g++) begin : g_stage
      ex_regincr_incr_stage #(
         .p_nbits (p_nbits),
         .p_incr  (p_incr),
         .p_mode  (c_mode)
      ) u_stage (
         .clk       (clk),
         .reset_n   (reset_n),
         .adv       (adv[g]),
         .prev_val  (prev_val[g]),
         .prev_data (prev_data[g]),
         .prev_ovf  (prev_ovf[g]),
         .val       (val[g]),
         .data      (data[g]),
         .ovf       (ovf[g])
      );
   end

   assign in_rdy   = reset_n & adv[0];
   assign out_val  = val[p_nstages-1];
   assign out_msg  = data[p_nstages-1];
   assign out_ovf  = ovf[p_nstages-1];
   assign in_fire  = in_val & in_rdy;
   assign out_fire = out_val & out_rdy;

   // Occupancy tracks accepted-but-not-delivered items.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         occ <= '0;
      end else begin
         case ({in_fire, out_fire})
            2'b10:   occ <= occ + c_occ_w'(1);
            2'b01:   occ <= occ - c_occ_w'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_regincr_reg_incr_pipe.sv
// Bench for ex_regincr_reg_incr_pipe: default, saturating and 16-bit/4-stage instances.
module tb_ex_regincr_reg_incr_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        iv[3];
   logic        ordy[3];
   logic [15:0] im[3];
   logic        ir[3];
   logic        ov[3];
   logic        oo[3];
   logic [15:0] om[3];
   logic [2:0]  oc[3];

   logic [7:0]  om0, om1;
   logic [15:0] om2;
   logic [1:0]  oc0, oc1;
   logic [2:0]  oc2;

   assign om[0] = {8'h00, om0};
   assign om[1] = {8'h00, om1};
   assign om[2] = om2;
   assign oc[0] = {1'b0, oc0};
   assign oc[1] = {1'b0, oc1};
   assign oc[2] = oc2;

   ex_regincr_reg_incr_pipe d0 (
      .clk(clk), .reset_n(reset_n), .in_val(iv[0]), .in_rdy(ir[0]), .in_msg(im[0][7:0]),
      .out_val(ov[0]), .out_rdy(ordy[0]), .out_msg(om0), .out_ovf(oo[0]), .occ(oc0));

   ex_regincr_reg_incr_pipe #(.p_sat(1)) d1 (
      .clk(clk), .reset_n(reset_n), .in_val(iv[1]), .in_rdy(ir[1]), .in_msg(im[1][7:0]),
      .out_val(ov[1]), .out_rdy(ordy[1]), .out_msg(om1), .out_ovf(oo[1]), .occ(oc1));

   ex_regincr_reg_incr_pipe #(.p_nbits(16), .p_nstages(4), .p_incr(3), .p_sat(0)) d2 (
      .clk(clk), .reset_n(reset_n), .in_val(iv[2]), .in_rdy(ir[2]), .in_msg(im[2]),
      .out_val(ov[2]), .out_rdy(ordy[2]), .out_msg(om2), .out_ovf(oo[2]), .occ(oc2));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int nb_of(input int g);
      return (g == 2) ? 16 : 8;
   endfunction
   function automatic int nst_of(input int g);
      return (g == 2) ? 4 : 2;
   endfunction
   function automatic int inc_of(input int g);
      return (g == 2) ? 3 : 1;
   endfunction
   function automatic int sat_of(input int g);
      return (g == 1) ? 1 : 0;
   endfunction

   // Reference: total added is nstages*incr; any stage overflows iff the true sum reaches 2**n.
   function automatic logic [16:0] model(input int g, input logic [15:0] x);
      longint lim, tot;
      logic [15:0] d;
      logic o;
      lim = longint'(1) << nb_of(g);
      tot = longint'(x) + longint'(nst_of(g)) * longint'(inc_of(g));
      if (tot >= lim) begin
         o = 1'b1;
         d = (sat_of(g) != 0) ? 16'(lim - 1) : 16'(tot % lim);
      end else begin
         o = 1'b0;
         d = 16'(tot);
      end
      return {o, d};
   endfunction

   // Scoreboard per DUT: queue of expected results, occupancy and ready derived from it.
   for (genvar g = 0; g < 3; g++) begin : g_mon
      logic [16:0] q[$];
      logic [16:0] e;
      int          pushed = 0;
      int          pending = 0;
      initial forever begin
         @(negedge clk);
         if (!reset_n) begin
            chk($sformatf("d%0d in_rdy during reset", g), {31'd0, ir[g]}, 32'd0);
            q.delete();
         end else begin
            chk($sformatf("d%0d occ", g), {29'd0, oc[g]}, q.size());
            chk($sformatf("d%0d in_rdy", g), {31'd0, ir[g]},
                {31'd0, (ordy[g] || (q.size() < nst_of(g)))});
            if (ov[g] && ordy[g]) begin
               if (q.size() == 0) begin
                  chk($sformatf("d%0d spurious output", g), 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("d%0d out_msg", g), {16'd0, om[g]}, {16'd0, e[15:0]});
                  chk($sformatf("d%0d out_ovf", g), {31'd0, oo[g]}, {31'd0, e[16]});
               end
            end
            if (iv[g] && ir[g]) begin
               q.push_back(model(g, im[g]));
               pushed++;
            end
         end
         pending = q.size();
      end
   end

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] msg;
      logic       ordy;
      logic       e_rdy;
      logic       e_val;
      logic [7:0] e_msg;
      logic       e_ovf;
      logic [1:0] e_occ;
      logic       cm;
   } vec_t;

   vec_t tbl[22];

   task automatic single(input int g, input logic [15:0] v, input logic [15:0] ed,
                         input logic eo, input string name);
      int  k;
      logic got;
      @(posedge clk); #1;
      iv[g] = 1'b1; im[g] = v; ordy[g] = 1'b1;
      @(negedge clk);
      chk({name, " accept"}, {31'd0, ir[g]}, 32'd1);
      k = 0; got = 1'b0;
      while (!got && k < 20) begin
         @(posedge clk); #1;
         iv[g] = 1'b0;
         @(negedge clk);
         k++;
         if (ov[g]) got = 1'b1;
      end
      chk({name, " out_val seen"}, {31'd0, got}, 32'd1);
      chk({name, " latency"}, k, nst_of(g));
      chk({name, " msg"}, {16'd0, om[g]}, {16'd0, ed});
      chk({name, " ovf"}, {31'd0, oo[g]}, {31'd0, eo});
   endtask

   initial begin
      logic [15:0] mask;
      reset_n = 1'b0;
      for (int g = 0; g < 3; g++) begin
         iv[g] = 1'b0; ordy[g] = 1'b0; im[g] = 16'h0000;
      end
      //          rst   iv    msg    ordy  e_rdy e_val e_msg  e_ovf e_occ cm
      tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 2'd1, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 8'h0A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 2'd2, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b0, 2'd1, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0C, 1'b0, 2'd1, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 2'd1, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 2'd2, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 2'd2, 1'b1};
      tbl[14] = '{1'b1, 1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 2'd2, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h32, 1'b0, 2'd2, 1'b1};
      tbl[16] = '{1'b1, 1'b1, 8'h50, 1'b1, 1'b1, 1'b1, 8'h42, 1'b0, 2'd1, 1'b1};
      tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
      tbl[18] = '{1'b1, 1'b1, 8'h60, 1'b0, 1'b1, 1'b1, 8'h52, 1'b0, 2'd1, 1'b1};
      tbl[19] = '{1'b0, 1'b1, 8'h70, 1'b0, 1'b0, 1'b1, 8'h52, 1'b0, 2'd2, 1'b1};
      tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
      tbl[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};

      repeat (2) @(posedge clk);

      for (int r = 0; r < 22; r++) begin
         @(posedge clk); #1;
         reset_n = tbl[r].rst;
         iv[0]   = tbl[r].iv;
         im[0]   = {8'h00, tbl[r].msg};
         ordy[0] = tbl[r].ordy;
         @(negedge clk);
         chk($sformatf("tbl[%0d] in_rdy", r), {31'd0, ir[0]}, {31'd0, tbl[r].e_rdy});
         chk($sformatf("tbl[%0d] out_val", r), {31'd0, ov[0]}, {31'd0, tbl[r].e_val});
         chk($sformatf("tbl[%0d] occ", r), {29'd0, oc[0]}, {30'd0, tbl[r].e_occ});
         if (tbl[r].cm) begin
            chk($sformatf("tbl[%0d] out_msg", r), {16'd0, om[0]}, {24'd0, tbl[r].e_msg});
            chk($sformatf("tbl[%0d] out_ovf", r), {31'd0, oo[0]}, {31'd0, tbl[r].e_ovf});
         end
      end

      // Back-to-back stream: one result per cycle, two in flight once filled.
      for (int j = 0; j < 18; j++) begin
         @(posedge clk); #1;
         iv[0] = (j < 16); im[0] = 16'(j); ordy[0] = 1'b1;
         @(negedge clk);
         chk($sformatf("stream[%0d] in_rdy", j), {31'd0, ir[0]}, 32'd1);
         if (j >= 2) begin
            chk($sformatf("stream[%0d] out_val", j), {31'd0, ov[0]}, 32'd1);
            chk($sformatf("stream[%0d] out_msg", j), {16'd0, om[0]}, j);
         end
         if (j >= 2 && j < 16) chk($sformatf("stream[%0d] occ", j), {29'd0, oc[0]}, 32'd2);
      end

      single(0, 16'h0005, 16'h0007, 1'b0, "wrap 05");
      single(0, 16'h00FF, 16'h0001, 1'b1, "wrap FF");
      single(1, 16'h00FF, 16'h00FF, 1'b1, "sat FF");
      single(1, 16'h00FD, 16'h00FF, 1'b0, "sat FD");
      single(2, 16'hFFF0, 16'hFFFC, 1'b0, "w16 FFF0");
      single(2, 16'hFFF8, 16'h0004, 1'b1, "w16 FFF8");

      for (int c = 0; c < 30000; c++) begin
         @(posedge clk); #1;
         for (int g = 0; g < 3; g++) begin
            mask    = 16'((32'd1 << nb_of(g)) - 32'd1);
            iv[g]   = ($urandom_range(3, 0) != 0);
            ordy[g] = ($urandom_range(3, 0) != 0);
            if ($urandom_range(3, 0) == 0) im[g] = mask - 16'($urandom_range(7, 0));
            else                           im[g] = 16'($urandom) & mask;
         end
      end

      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         for (int g = 0; g < 3; g++) begin
            iv[g] = 1'b0; ordy[g] = 1'b1;
         end
      end
      @(negedge clk);
      chk("d0 drained", g_mon[0].pending, 32'd0);
      chk("d1 drained", g_mon[1].pending, 32'd0);
      chk("d2 drained", g_mon[2].pending, 32'd0);
      chk("d0 item count", {31'd0, (g_mon[0].pushed >= 10000)}, 32'd1);
      chk("d1 item count", {31'd0, (g_mon[1].pushed >= 10000)}, 32'd1);
      chk("d2 item count", {31'd0, (g_mon[2].pushed >= 10000)}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
